instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Fetch-side initiator for the synchronous instruction ROM (addr/en/rst in, registered dout out,
//   1-cycle read latency, dout held while en=0). Generates sequential PCs, issues ROM reads,
//   pairs each returned word with its PC and hands {pc,instr} to decode over a valid/ready link.
//   Handles decode backpressure with a 1-entry skid buffer and flushes on branch/jump redirect.
// PARAMETERS
//   RESET_PC  32'h0  first fetch address after reset release
//   PC_STEP   4      byte increment between sequential fetches
// PORTS
//   clk             in   1   clock
//   rst_n           in   1   reset, asynchronous, active-low
//   imem_addr       out  32  ROM byte address
//   imem_en         out  1   ROM read enable; dout updates next edge only when 1
//   imem_rst        out  1   ROM synchronous reset = ~rst_n
//   imem_dout       in   32  ROM read data, valid the cycle after an enabled read
//   redirect_valid  in   1   jump/branch taken, from execute
//   redirect_pc     in   32  redirect target; bits [1:0] ignored (treated as 00)
//   if_valid        out  1   {if_pc,if_instr} valid to decode
//   if_ready        in   1   decode accepts this cycle
//   if_pc           out  32  PC of presented instruction
//   if_instr        out  32  presented instruction word
// BEHAVIOUR
//   Reset is asynchronous and active-low: rst_n low -> pc=RESET_PC, resp_valid=0, skid_valid=0
//   immediately; if_valid=0, imem_en=0, imem_addr=RESET_PC, imem_rst=1 while rst_n low.
//   State: pc (next addr to issue), resp_valid/resp_pc (read issued last cycle, data on imem_dout),
//   skid_valid/skid_pc/skid_instr.
//   issue = rst_n & (redirect_valid | ~skid_valid). imem_en = issue.
//   imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : pc.
//   On issue: pc <= imem_addr + PC_STEP (mod 2^32, wraps), resp_valid <= 1, resp_pc <= imem_addr.
//   Output select: skid_valid ? skid entry : resp entry (imem_dout, resp_pc);
//   if_valid = ~redirect_valid & (skid_valid | resp_valid). Ordering always skid before resp.
//   Non-redirect cycle cases:
//     skid empty, resp valid, ready=1 : resp consumed; issue continues -> 1 instr/cycle.
//     skid empty, resp valid, ready=0 : resp copied to skid; issue this cycle (skid was empty).
//     skid full, ready=0              : hold all; imem_en=0 so imem_dout and resp stay stable.
//     skid full, ready=1              : skid consumed/cleared; resp (if any) stays pending on
//                                       held dout, shown next cycle; issue resumes next cycle.
//     no issue and resp consumed or moved to skid -> resp_valid <= 0.
//   imem_en never depends combinationally on if_ready (only on registered skid_valid, redirect).
//   Redirect (priority over stall and all else): skid_valid <= 0; in-flight resp discarded;
//   target issued in the same cycle; first redirected instr valid on if_* the next cycle.
//   Max 2 fetched-not-consumed instrs (skid + resp); no instruction lost or duplicated.
//   Latency: reset release -> first if_valid 1 cycle later; redirect -> target valid 1 cycle later.
// TESTING
//   1 ROM {0:00000013,4:008000ef,8:00a00113,12:01400193}, ready=1 after reset -> if_pc 0,4,8,12
//     on consecutive cycles with matching words, first valid 1 cycle after rst_n rises.
//   2 ready=0 for 3 cycles while pc 8 presented -> if_pc/if_instr held at 8/00a00113, imem_en=0
//     once skid full; after ready=1 sequence continues 12,16 with no gap beyond 1 cycle, no dup.
//   3 redirect_valid=1, redirect_pc=12 while skid and resp both full -> if_valid=0 that cycle;
//     next cycle if_pc=12, if_instr=01400193; pcs 4/8 never accepted afterwards.
//   4 redirect_valid=1 with if_ready=0 same cycle, redirect_pc=0x00000006 -> issue addr 0x4,
//     skid flushed, next valid if_pc=4.
//   5 rst_n pulsed low between edges mid-stream -> if_valid and imem_en drop at once; after
//     release fetch restarts at RESET_PC.
//   6 RESET_PC=32'hFFFFFFFC, ready=1 -> if_pc FFFFFFFC then 00000000.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch-side initiator for a synchronous instruction ROM with 1-cycle read
//   latency. Issues sequential PCs, pairs each returned word with the PC it
//   was fetched from and presents {pc, instr} to decode over valid/ready.
//
//   Storage for fetched-but-not-consumed instructions:
//     - resp : the read issued last cycle; its word sits on imem_dout.
//     - skid : a single-entry buffer that catches resp when decode stalls.
//   At most two instructions are outstanding (skid + resp). Decode always
//   sees the skid entry first because it is the older of the two.
//
//   The ROM enable depends only on registered state (skid occupancy) and on
//   the redirect input. It never depends on if_ready, so decode backpressure
//   does not form a combinational path into the ROM address/enable.
//
//   A redirect flushes both entries and issues the target in the same cycle.
//   The target's word is presented one cycle later.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction ROM side
  output logic [31:0] imem_addr,
  output logic        imem_en,
  output logic        imem_rst,
  input  logic [31:0] imem_dout,
  // redirect from execute
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // decode side
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] pc_q,         pc_d;          // next sequential address to issue
  logic        resp_valid_q, resp_valid_d;  // a read was issued last cycle
  logic [31:0] resp_pc_q,    resp_pc_d;     // address of that read
  logic        skid_valid_q, skid_valid_d;  // skid entry occupied
  logic [31:0] skid_pc_q,    skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [31:0] redirect_addr_s;   // word-aligned redirect target
  logic [31:0] fetch_addr_s;      // address presented to the ROM when issuing
  logic        issue_s;           // a ROM read is started this cycle
  logic        present_valid_s;   // something is available for decode
  logic        accept_s;          // decode takes the presented entry

  // Issue decision, fetch address and the decode-facing view of the buffers
  always_comb begin
    redirect_addr_s = {redirect_pc[31:2], 2'b00};
    fetch_addr_s    = redirect_valid ? redirect_addr_s : pc_q;

    // A full skid buffer means resp is also occupied; a further read would
    // overwrite the word resp still needs, so issue only when skid is empty.
    // A redirect discards both entries, so it may always issue.
    issue_s         = rst_n & (redirect_valid | ~skid_valid_q);

    present_valid_s = skid_valid_q | resp_valid_q;
    accept_s        = if_valid & if_ready;
  end

  // ROM and decode output drive
  always_comb begin
    imem_rst  = ~rst_n;
    imem_en   = issue_s;
    if (rst_n) begin
      imem_addr = fetch_addr_s;
    end else begin
      imem_addr = RESET_PC;
    end

    // Nothing is offered on a redirect cycle: whatever is buffered belongs
    // to the discarded path.
    if_valid = rst_n & ~redirect_valid & present_valid_s;

    if (skid_valid_q) begin
      if_pc    = skid_pc_q;
      if_instr = skid_instr_q;
    end else begin
      if_pc    = resp_pc_q;
      if_instr = imem_dout;
    end
  end

  // Next-state for the skid entry
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (redirect_valid) begin
      // flush: the buffered instruction is on the wrong path
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // skid is presented; it leaves only when decode takes it
      if (accept_s) begin
        skid_valid_d = 1'b0;
      end else begin
        skid_valid_d = 1'b1;
      end
    end else if (resp_valid_q && !if_ready) begin
      // resp is presented but stalled; park it before the ROM output moves
      skid_valid_d = 1'b1;
      skid_pc_d    = resp_pc_q;
      skid_instr_d = imem_dout;
    end else begin
      skid_valid_d = 1'b0;
    end
  end

  // Next-state for the in-flight response and the sequential PC
  always_comb begin
    pc_d         = pc_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;

    if (issue_s) begin
      // the new read becomes the response seen next cycle; PC wraps mod 2^32
      pc_d         = fetch_addr_s + PC_STEP;
      resp_valid_d = 1'b1;
      resp_pc_d    = fetch_addr_s;
    end else if (skid_valid_q) begin
      // ROM held (en=0): resp keeps waiting behind the skid entry
      resp_valid_d = resp_valid_q;
    end else begin
      // no issue and resp was consumed or moved to skid
      resp_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0000_0000;
      skid_instr_q <= 32'h0000_0000;
    end else begin
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Two fetch units share clock and reset: dut0 (RESET_PC=0) gets randomized
//   ready/redirect traffic and is checked every cycle against a queue model of
//   the fetch stream; dut1 (RESET_PC=FFFFFFFC) checks PC wrap-around.
//   Each DUT is attached to a behavioural synchronous ROM.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC0 = 32'h0000_0000;
  localparam logic [31:0] RST_PC1 = 32'hFFFF_FFFC;
  localparam logic [31:0] STEP    = 32'h0000_0004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // dut0
  logic [31:0] imem_addr;
  logic        imem_en;
  logic        imem_rst;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  // dut1
  logic [31:0] b_imem_addr;
  logic        b_imem_en;
  logic        b_imem_rst;
  logic [31:0] b_imem_dout;
  logic        b_redirect_valid = 1'b0;
  logic [31:0] b_redirect_pc    = 32'h0000_0000;
  logic        b_if_valid;
  logic        b_if_ready       = 1'b1;
  logic [31:0] b_if_pc;
  logic [31:0] b_if_instr;

  int checks   = 0;
  int failures = 0;

  instruction_fetch_unit #(.RESET_PC(RST_PC0), .PC_STEP(STEP)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rst(imem_rst), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  instruction_fetch_unit #(.RESET_PC(RST_PC1), .PC_STEP(STEP)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(b_imem_addr), .imem_en(b_imem_en), .imem_rst(b_imem_rst), .imem_dout(b_imem_dout),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .if_valid(b_if_valid), .if_ready(b_if_ready), .if_pc(b_if_pc), .if_instr(b_if_instr)
  );

  // ROM contents: a small known program, and an address-derived word elsewhere
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'd0:   rom_word = 32'h0000_0013;
      32'd4:   rom_word = 32'h0080_00ef;
      32'd8:   rom_word = 32'h00a0_0113;
      32'd12:  rom_word = 32'h0140_0193;
      default: rom_word = {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1E0F};
    endcase
  endfunction

  // Synchronous ROMs: registered dout, held while en=0, cleared by sync reset
  always @(posedge clk) begin
    if (imem_rst)      imem_dout <= 32'h0;
    else if (imem_en)  imem_dout <= rom_word(imem_addr);
  end
  always @(posedge clk) begin
    if (b_imem_rst)     b_imem_dout <= 32'h0;
    else if (b_imem_en) b_imem_dout <= rom_word(b_imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: the fetch stream as a queue of fetched-not-consumed PCs
  // (capacity 2). Head is what decode must see; a new address is fetched
  // whenever fewer than two are outstanding; a redirect replaces everything.
  // --------------------------------------------------------------------------
  logic [31:0] mq[$];
  logic [31:0] m_next;
  logic        m_valid, m_en;
  logic [31:0] m_addr, m_tgt;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_imem_en",  32'(imem_en),  32'd0);
      chk("rst_imem_rst", 32'(imem_rst), 32'd1);
      chk("rst_imem_addr", imem_addr, RST_PC0);
      mq.delete();
      m_next = RST_PC0;
    end else begin
      m_tgt   = {redirect_pc[31:2], 2'b00};
      m_valid = !redirect_valid && (mq.size() > 0);
      m_en    = redirect_valid || (mq.size() < 2);
      m_addr  = redirect_valid ? m_tgt : m_next;
      chk("m_if_valid", 32'(if_valid), 32'(m_valid));
      chk("m_imem_en",  32'(imem_en),  32'(m_en));
      chk("m_imem_rst", 32'(imem_rst), 32'd0);
      if (m_valid) begin
        chk("m_if_pc",    if_pc,    mq[0]);
        chk("m_if_instr", if_instr, rom_word(mq[0]));
      end
      if (m_en) chk("m_imem_addr", imem_addr, m_addr);
      if (redirect_valid) begin
        mq.delete();
        mq.push_back(m_tgt);
        m_next = m_tgt + STEP;
      end else begin
        if (m_valid && if_ready) void'(mq.pop_front());
        if (m_en) begin
          mq.push_back(m_next);
          m_next = m_next + STEP;
        end
      end
    end
  end

  // Apply one cycle of inputs just after the rising edge, return at the falling edge
  task automatic drive(input logic rn, input logic rdy, input logic rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst_n          = rn;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(posedge clk);

    // sequential fetch after reset release, first valid one cycle later
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t1_first_cycle_invalid", 32'(if_valid), 32'd0);
    chk("t6_first_cycle_invalid", 32'(b_if_valid), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t1_valid_pc0", 32'(if_valid), 32'd1);
    chk("t1_pc0", if_pc, 32'h0000_0000);
    chk("t1_instr0", if_instr, 32'h0000_0013);
    chk("t6_pc_fffffffc", b_if_pc, 32'hFFFF_FFFC);
    chk("t6_valid_a", 32'(b_if_valid), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t1_pc4", if_pc, 32'h0000_0004);
    chk("t1_instr4", if_instr, 32'h0080_00ef);
    chk("t6_pc_wrap0", b_if_pc, 32'h0000_0000);
    chk("t6_valid_b", 32'(b_if_valid), 32'd1);

    // stall while pc 8 is presented
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_pc8", if_pc, 32'h0000_0008);
    chk("t2_instr8", if_instr, 32'h00a0_0113);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t2_hold_pc8", if_pc, 32'h0000_0008);
      chk("t2_hold_instr8", if_instr, 32'h00a0_0113);
      chk("t2_en_low_skid_full", 32'(imem_en), 32'd0);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t2_release_pc8", if_pc, 32'h0000_0008);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t2_pc12", if_pc, 32'h0000_000C);
    chk("t2_instr12", if_instr, 32'h0140_0193);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_pc16", if_pc, 32'h0000_0010);

    // redirect to 12 while skid and resp are both full
    drive(1'b1, 1'b0, 1'b1, 32'h0000_000C);
    chk("t3_redirect_invalid", 32'(if_valid), 32'd0);
    chk("t3_redirect_addr", imem_addr, 32'h0000_000C);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_pc12", if_pc, 32'h0000_000C);
    chk("t3_instr12", if_instr, 32'h0140_0193);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t3_pc16", if_pc, 32'h0000_0010);

    // misaligned redirect with decode stalled
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0006);
    chk("t4_addr_aligned", imem_addr, 32'h0000_0004);
    chk("t4_redirect_invalid", 32'(if_valid), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t4_pc4", if_pc, 32'h0000_0004);
    chk("t4_instr4", if_instr, 32'h0080_00ef);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t4_pc8", if_pc, 32'h0000_0008);

    // asynchronous reset pulse between edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid_drop", 32'(if_valid), 32'd0);
    chk("t5_async_en_drop", 32'(imem_en), 32'd0);
    chk("t5_async_imem_rst", 32'(imem_rst), 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t5_restart_invalid", 32'(if_valid), 32'd0);
    chk("t5_restart_addr", imem_addr, RST_PC0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t5_restart_pc0", if_pc, 32'h0000_0000);
    chk("t5_restart_valid", 32'(if_valid), 32'd1);

    // randomized ready / redirect / occasional reset traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r_rn, r_rdy, r_rv;
      logic [31:0] r_pc;
      r_rn  = ($urandom_range(0, 299) != 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rv  = ($urandom_range(0, 11) == 0);
      r_pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 255));
      drive(r_rn, r_rdy, r_rv, r_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
